ch1_sweep_freq: RTL
===================

# ch1_sweep_freq

Channel 1 frequency datapath, directly downstream of the channel 1 control/sweep sequencer. It holds the 11-bit frequency (FF13/FF14), the sweep shadow shift register and the add/subtract unit, and it reports overflow back to the sequencer as `atys`. It also contains the frequency period counter that produces the duty-step tick `copu`. The sequencer drives the strobes `ch1_restart`, `ch1_ld_shift`, `ch1_shift_clk`, `ch1_freq_upd1` and `ch1_freq_upd2`, and consumes `atys` and `copu`.

## Interface
Parameters:
- FREQ_W, 11, frequency/shadow/counter width

Ports:
- `ajer_2mhz`  in  1  sole clock, rising edge
- `apu_reset`  in  1  reset, asynchronous, active-high
- `d`  in  8  CPU write data
- `apu_wr`  in  1  CPU write strobe
- `ff13`  in  1  FF13 selected (frequency low byte)
- `ff14`  in  1  FF14 selected (`d[2:0]` are frequency bits 10:8)
- `ff10_d3`  in  1  sweep direction: 0 add, 1 subtract
- `dyfa_1mhz`  in  1  period-counter clock enable, high every other `ajer_2mhz` cycle
- `ch1_restart`  in  1  trigger pulse
- `ch1_ld_shift`  in  1  load shadow from frequency
- `ch1_shift_clk`  in  1  one shadow right-shift step
- `ch1_freq_upd1`  in  1  commit sum bits 7:0 into frequency
- `ch1_freq_upd2`  in  1  commit sum bits 10:8 into frequency
- `ch1_freq`  out  11  current frequency register
- `atys`  out  1  1 = no overflow, update permitted
- `copu`  out  1  period-counter wrap tick, one cycle wide

## Operation
- All strobe inputs are synchronous, level-sampled per clock, and take effect at the next edge.
- `apu_wr && ff13` loads `freq[7:0] <= d`.
- `apu_wr && ff14` loads `freq[10:8] <= d[2:0]`.
- `ch1_ld_shift` loads `shadow <= freq`.
- `ch1_shift_clk` logical-right-shifts `shadow` by 1 (zero fill). If both strobes are asserted in the same cycle, load wins.
- Sum, 12-bit:
  - `ff10_d3 = 0`: `sum = {0,freq} + {0,shadow}`.
  - `ff10_d3 = 1`: `sum = {0,freq} - {0,shadow}`, truncated to 12 bits.
- `atys = !(~ff10_d3 && sum[11])`. Subtract never flags; an underflow wraps modulo 2048.
- Commit:
  - `ch1_freq_upd1 && atys` sets `freq[7:0] <= sum[7:0]`.
  - `ch1_freq_upd2 && atys` sets `freq[10:8] <= sum[10:8]`.
  - With `atys = 0` the frequency holds.
- Simultaneous CPU write and commit: the CPU write wins for the byte it targets; the other field still commits.
- Period counter `cnt[10:0]`:
  - `ch1_restart` sets `cnt <= freq` and `copu <= 0`.
  - Otherwise, on a `dyfa_1mhz` cycle: if `cnt == 2047`, then `cnt <= freq` and `copu <= 1`; else `cnt <= cnt+1` and `copu <= 0`.
  - On non-enable cycles `copu <= 0`.
  - Restart and enable in the same cycle: restart wins, no tick.
- Period = `(2048 - freq)` enables. A frequency change takes effect at the next reload, not mid-count.
- Reset: `freq`, `shadow`, `cnt` = 0; `copu` = 0; `ch1_freq` = 0; `atys` = 1. Asserting reset mid-operation clears all state immediately; the first strobe after release acts normally.

## Timing
- Register writes, load, shift and commit are visible on `ch1_freq`/`sum` one clock after the strobe.
- `atys` is combinational from the registered `freq`/`shadow` and `ff10_d3`. It is valid in the same cycle as the state it reflects, so the sequencer may issue upd in the cycle after the last shift.
- `copu` is registered. It is high for exactly one `ajer_2mhz` cycle, in the cycle after the enable edge at which `cnt` was 2047.
- No handshake; the sequencer guarantees strobe ordering.

## Structure
- Shared package `apu_pkg`: `FREQ_W = 11`, `typedef logic [FREQ_W-1:0] freq_t`, `FREQ_MAX = 11'h7FF`.
- One sub-module, `ch1_freq_counter`, covering `cnt`, reload and the `copu` tick. Sum, shadow and frequency registers live in the top level.

## Test plan
- Add path: write FF13 = 0x00, FF14 = 0x04; then ld_shift and 1 shift → shadow = 0x200, sum = 0x600, atys = 1; then upd1+upd2 → `ch1_freq` = 0x600.
- Overflow blocks the commit: freq = 0x700, ld_shift, no shift → sum = 0xE00, atys = 0; then upd1+upd2 → `ch1_freq` stays 0x700.
- Subtract: freq = 0x400, ff10_d3 = 1, ld, 2 shifts → shadow = 0x100, commit → 0x300. With freq = 0x000 and shadow = 0x001 → wraps to 0x7FF, atys = 1.
- Write/commit collision: FF13 write 0x55 in the same cycle as upd1+upd2 with sum = 0x6AA → `ch1_freq` = 0x655.
- Counter: freq = 0x7FE, restart, `dyfa_1mhz` toggling → `copu` pulses every 2 enables (every 4 clocks), one cycle wide. Restart coincident with the wrap enable → no pulse.
- Async reset mid-count with freq = 0x123 → all outputs immediately 0 and atys = 1; `copu` stays 0 until 2048 enables after release.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg
//   Shared APU definitions used by the channel 1 frequency datapath.
//   FREQ_W   : width of the frequency, sweep shadow and period counter
//   freq_t   : 11-bit frequency value type
//   FREQ_MAX : largest frequency / counter value; the period counter wraps here
package apu_pkg;

   localparam int FREQ_W = 11;

   typedef logic [FREQ_W-1:0] freq_t;

   localparam freq_t FREQ_MAX = 11'h7FF;

endpackage : apu_pkg

// File: rtl/ch1_freq_counter.sv
// ch1_freq_counter
//   Channel 1 frequency period counter. It counts up from the programmed
//   frequency to FREQ_MAX on each enable, then reloads and emits a
//   one-cycle tick. The period is therefore (2048 - freq) enables.
//   Ports:
//     clk     : clock, rising edge
//     rst     : asynchronous active-high reset
//     freq    : current frequency register, sampled only at a reload
//     restart : reload the counter from freq and suppress any tick
//     en      : count enable (1 MHz phase)
//     copu    : registered wrap tick, one clock wide
module ch1_freq_counter
   import apu_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  freq_t freq,
   input  logic  restart,
   input  logic  en,
   output logic  copu
);

   freq_t cnt_q;
   freq_t cnt_d;
   logic  copu_q;
   logic  copu_d;

   // Restart has priority over an enable, so a restart that lands on the
   // wrap enable reloads the counter without producing a tick. The tick
   // defaults low every cycle, which keeps it exactly one clock wide.
   always_comb begin
      cnt_d  = cnt_q;
      copu_d = 1'b0;
      if (restart) begin
         cnt_d = freq;
      end else if (en) begin
         if (cnt_q == FREQ_MAX) begin
            cnt_d  = freq;
            copu_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         copu_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         copu_q <= copu_d;
      end
   end

   assign copu = copu_q;

endmodule : ch1_freq_counter

// File: rtl/ch1_sweep_freq.sv
// ch1_sweep_freq
//   Channel 1 frequency datapath. It holds the 11-bit frequency written
//   through FF13/FF14, the sweep shadow shift register and the sweep
//   add/subtract unit. It reports overflow (atys) to the sequencer and
//   hosts the period counter that generates the duty-step tick (copu).
//   Ports:
//     ajer_2mhz      : clock, rising edge
//     apu_reset      : asynchronous active-high reset
//     d              : CPU write data
//     apu_wr         : CPU write strobe
//     ff13 / ff14    : register selects (low byte / bits 10:8 in d[2:0])
//     ff10_d3        : sweep direction, 0 add, 1 subtract
//     dyfa_1mhz      : period-counter enable
//     ch1_restart    : trigger, reloads the period counter
//     ch1_ld_shift   : load shadow from frequency
//     ch1_shift_clk  : shift shadow right by one
//     ch1_freq_upd1  : commit sum[7:0] into frequency
//     ch1_freq_upd2  : commit sum[10:8] into frequency
//     ch1_freq       : current frequency register
//     atys           : 1 = no overflow, commit permitted
//     copu           : period-counter wrap tick
module ch1_sweep_freq #(
   parameter int FREQ_W = apu_pkg::FREQ_W
) (
   input  logic              ajer_2mhz,
   input  logic              apu_reset,
   input  logic [7:0]        d,
   input  logic              apu_wr,
   input  logic              ff13,
   input  logic              ff14,
   input  logic              ff10_d3,
   input  logic              dyfa_1mhz,
   input  logic              ch1_restart,
   input  logic              ch1_ld_shift,
   input  logic              ch1_shift_clk,
   input  logic              ch1_freq_upd1,
   input  logic              ch1_freq_upd2,
   output logic [FREQ_W-1:0] ch1_freq,
   output logic              atys,
   output logic              copu
);

   logic [FREQ_W-1:0] freq_q;
   logic [FREQ_W-1:0] freq_d;
   logic [FREQ_W-1:0] shadow_q;
   logic [FREQ_W-1:0] shadow_d;
   logic [FREQ_W:0]   sum;

   // One extra bit holds the carry. A subtract that underflows leaves a
   // borrow in the top bit, but only the add direction treats that bit as
   // an overflow; a subtract simply wraps modulo 2048.
   always_comb begin
      if (ff10_d3) begin
         sum = {1'b0, freq_q} - {1'b0, shadow_q};
      end else begin
         sum = {1'b0, freq_q} + {1'b0, shadow_q};
      end
   end

   assign atys = ~(~ff10_d3 & sum[FREQ_W]);

   // Each field is updated independently: a CPU write to a field beats a
   // sweep commit to that same field, while the other field can still take
   // its commit in the same cycle.
   always_comb begin
      freq_d = freq_q;
      if (apu_wr && ff13) begin
         freq_d[7:0] = d;
      end else if (ch1_freq_upd1 && atys) begin
         freq_d[7:0] = sum[7:0];
      end
      if (apu_wr && ff14) begin
         freq_d[FREQ_W-1:8] = d[FREQ_W-9:0];
      end else if (ch1_freq_upd2 && atys) begin
         freq_d[FREQ_W-1:8] = sum[FREQ_W-1:8];
      end
   end

   // A load takes priority over a shift asserted in the same cycle.
   always_comb begin
      shadow_d = shadow_q;
      if (ch1_ld_shift) begin
         shadow_d = freq_q;
      end else if (ch1_shift_clk) begin
         shadow_d = shadow_q >> 1;
      end
   end

   always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
      if (apu_reset) begin
         freq_q   <= '0;
         shadow_q <= '0;
      end else begin
         freq_q   <= freq_d;
         shadow_q <= shadow_d;
      end
   end

   assign ch1_freq = freq_q;

   ch1_freq_counter u_counter (
      .clk     (ajer_2mhz),
      .rst     (apu_reset),
      .freq    (freq_q),
      .restart (ch1_restart),
      .en      (dyfa_1mhz),
      .copu    (copu)
   );

endmodule : ch1_sweep_freq
